// File: rtl/fp_addsub_pkg.sv
// Shared types and sizing for the FP add/sub datapath.
package fp_addsub_pkg;

  localparam int DEF_EXP_WIDTH  = 8;
  localparam int DEF_MANT_WIDTH = 23;

  // The aligned significand is the hidden bit, the fraction, and then guard, round and sticky.
  function automatic int sig_w(input int mant_w);
    return mant_w + 4;
  endfunction

  typedef struct packed {
    logic                      sign;
    logic [DEF_EXP_WIDTH-1:0]  exp;
    logic [DEF_MANT_WIDTH-1:0] mant;
  } fp_unpacked_t;

  typedef enum logic [1:0] {A_GT, A_LT, A_EQ} align_cmp_e;

endpackage

// File: rtl/exp_align_pipe_if.sv
// Operand-in / aligned-out handshake bundle for exp_align_pipe.
interface exp_align_pipe_if
  import fp_addsub_pkg::*;
#(
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH
);
  localparam int SIG_W = sig_w(MANT_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic                  sign_a, sign_b;
  logic [EXP_WIDTH-1:0]  exp_a, exp_b;
  logic [MANT_WIDTH-1:0] mant_a, mant_b;

  logic                  out_valid;
  logic                  out_ready;
  logic [EXP_WIDTH-1:0]  exp_big;
  logic                  sign_big, sign_small;
  logic [SIG_W-1:0]      sig_big, sig_small;
  logic                  swapped;
  logic                  a_greater, a_less, a_equal;

  modport slave (
    input  in_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, exp_big, sign_big, sign_small, sig_big, sig_small,
           swapped, a_greater, a_less, a_equal
  );

  modport master (
    output in_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, exp_big, sign_big, sign_small, sig_big, sig_small,
           swapped, a_greater, a_less, a_equal
  );
endinterface

// File: rtl/exp_align_pipe_shifter.sv
// Combinational right shifter that folds every shifted-out bit into bit 0 (sticky).
module align_shifter #(
  parameter int W  = 27,
  parameter int SW = 8
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  dout
);
  localparam logic [31:0] W_U = W;

  logic [W-1:0] lost_mask;

  // Shift, then OR the lost bits into the LSB; huge shifts collapse to a lone sticky bit.
  always_comb begin
    lost_mask = ~({W{1'b1}} << shamt);
    dout      = '0;
    if (32'(shamt) >= W_U) begin
      dout[0] = |din;
    end else begin
      dout    = din >> shamt;
      dout[0] = dout[0] | (|(din & lost_mask));
    end
  end
endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent compare and significand alignment front end for FP add/sub.
module exp_align_pipe
  import fp_addsub_pkg::*;
#(
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  exp_align_pipe_if.slave bus
);
  localparam int SIG_W  = sig_w(MANT_WIDTH);
  localparam int HW     = MANT_WIDTH + 1;
  localparam int KW     = EXP_WIDTH + HW;
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_load, s2_load;

  // Unpack: denormals use exponent 1 and no hidden bit.
  logic                 hid_a, hid_b;
  logic [EXP_WIDTH-1:0] eff_a, eff_b;
  logic [KW-1:0]        key_a, key_b;
  logic                 a_big;
  align_cmp_e           cmp;

  assign hid_a = |bus.exp_a;
  assign hid_b = |bus.exp_b;
  assign eff_a = hid_a ? bus.exp_a : EXP_WIDTH'(1);
  assign eff_b = hid_b ? bus.exp_b : EXP_WIDTH'(1);
  assign key_a = {eff_a, hid_a, bus.mant_a};
  assign key_b = {eff_b, hid_b, bus.mant_b};
  assign a_big = key_a >= key_b;
  assign cmp   = (key_a > key_b) ? A_GT : (key_a < key_b) ? A_LT : A_EQ;

  // Stage 2 frees up when empty or draining; stage 1 frees up when empty or moving on.
  assign s2_load      = !vld_pipe[2] || bus.out_ready;
  assign s1_load      = !vld_pipe[1] || s2_load;
  assign bus.in_ready = s1_load;
  assign bus.out_valid = vld_pipe[2];

  logic [EXP_WIDTH-1:0] s1_exp_big, s1_diff;
  logic [HW-1:0]        s1_sig_big, s1_sig_small;
  logic                 s1_sign_big, s1_sign_small, s1_swapped;
  align_cmp_e           s1_cmp;

  // Stage 1: swap so the larger magnitude is "big" and capture the exponent gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1]   <= 1'b0;
      s1_exp_big    <= '0;
      s1_diff       <= '0;
      s1_sig_big    <= '0;
      s1_sig_small  <= '0;
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_swapped    <= 1'b0;
      s1_cmp        <= A_EQ;
    end else if (s1_load) begin
      vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cmp     <= cmp;
        s1_swapped <= !a_big;
        if (a_big) begin
          s1_exp_big    <= eff_a;
          s1_diff       <= eff_a - eff_b;
          s1_sig_big    <= {hid_a, bus.mant_a};
          s1_sig_small  <= {hid_b, bus.mant_b};
          s1_sign_big   <= bus.sign_a;
          s1_sign_small <= bus.sign_b;
        end else begin
          s1_exp_big    <= eff_b;
          s1_diff       <= eff_b - eff_a;
          s1_sig_big    <= {hid_b, bus.mant_b};
          s1_sig_small  <= {hid_a, bus.mant_a};
          s1_sign_big   <= bus.sign_b;
          s1_sign_small <= bus.sign_a;
        end
      end
    end
  end

  logic [SIG_W-1:0] small_aligned;

  align_shifter #(.W(SIG_W), .SW(EXP_WIDTH)) u_shift (
    .din   ({s1_sig_small, 3'b000}),
    .shamt (s1_diff),
    .dout  (small_aligned)
  );

  // Stage 2: register aligned significands; hold everything while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2]    <= 1'b0;
      bus.exp_big    <= '0;
      bus.sign_big   <= 1'b0;
      bus.sign_small <= 1'b0;
      bus.sig_big    <= '0;
      bus.sig_small  <= '0;
      bus.swapped    <= 1'b0;
      bus.a_greater  <= 1'b0;
      bus.a_less     <= 1'b0;
      bus.a_equal    <= 1'b0;
    end else if (s2_load) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        bus.exp_big    <= s1_exp_big;
        bus.sign_big   <= s1_sign_big;
        bus.sign_small <= s1_sign_small;
        bus.sig_big    <= {s1_sig_big, 3'b000};
        bus.sig_small  <= small_aligned;
        bus.swapped    <= s1_swapped;
        bus.a_greater  <= (s1_cmp == A_GT);
        bus.a_less     <= (s1_cmp == A_LT);
        bus.a_equal    <= (s1_cmp == A_EQ);
      end
    end
  end
endmodule

// File: tb/tb_exp_align_pipe.sv
// Directed bench for exp_align_pipe: alignment, swap, sticky, saturation, stalls, reset.
module tb_exp_align_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  exp_align_pipe_if bus ();

  exp_align_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    bus.sign_a = sa; bus.exp_a = ea; bus.mant_a = ma;
    bus.sign_b = sb; bus.exp_b = eb; bus.mant_b = mb;
  endtask

  task automatic run_pair(input string tag,
                          input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                          input logic sb, input logic [7:0] eb, input logic [22:0] mb,
                          input logic [7:0] xe, input logic [26:0] xbig, input logic [26:0] xsmall,
                          input logic xsw, input logic xgt, input logic xlt, input logic xeq,
                          input logic xsbig, input logic xssmall);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(sa, ea, ma, sb, eb, mb);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"},     32'(bus.out_valid),  32'd1);
    chk({tag, "_exp_big"},   32'(bus.exp_big),    32'(xe));
    chk({tag, "_sig_big"},   32'(bus.sig_big),    32'(xbig));
    chk({tag, "_sig_small"}, 32'(bus.sig_small),  32'(xsmall));
    chk({tag, "_swapped"},   32'(bus.swapped),    32'(xsw));
    chk({tag, "_flags"},     32'({bus.a_greater, bus.a_less, bus.a_equal}), 32'({xgt, xlt, xeq}));
    chk({tag, "_signs"},     32'({bus.sign_big, bus.sign_small}), 32'({xsbig, xssmall}));
    @(posedge clk); #1;
  endtask

  initial begin
    int ni, no;
    bit stalled, saw_low;
    logic [7:0]  hold_exp;
    logic [26:0] hold_small;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 8'h00, 23'h0, 1'b0, 8'h00, 23'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_data", 32'(bus.sig_big | bus.sig_small), 32'd0);
    chk("rst_flags", 32'({bus.exp_big, bus.swapped, bus.a_greater, bus.a_less, bus.a_equal}), 32'd0);
    @(posedge clk); #1;

    // 1.0*2^3 vs 1.5*2^1: small shifts right by 2.
    run_pair("basic", 0, 8'h82, 23'h0, 0, 8'h80, 23'h400000,
             8'h82, 27'h4000000, 27'h1800000, 0, 1, 0, 0, 0, 0);
    // b larger, signs follow the swap; shifted-out bits are zero here.
    run_pair("swap", 1, 8'h7F, 23'h000003, 0, 8'h81, 23'h0,
             8'h81, 27'h4000000, 27'h1000006, 1, 0, 1, 0, 0, 1);
    // diff 4 drops a set bit into the sticky position.
    run_pair("sticky", 0, 8'h7D, 23'h000003, 0, 8'h81, 23'h0,
             8'h81, 27'h4000000, 27'h0400001, 1, 0, 1, 0, 0, 0);
    run_pair("sat", 0, 8'h9F, 23'h0, 0, 8'h80, 23'h0,
             8'h9F, 27'h4000000, 27'h0000001, 0, 1, 0, 0, 0, 0);
    run_pair("sat_zero", 0, 8'h9F, 23'h0, 0, 8'h00, 23'h0,
             8'h9F, 27'h4000000, 27'h0000000, 0, 1, 0, 0, 0, 0);
    run_pair("equal", 0, 8'h80, 23'h123456, 1, 8'h80, 23'h123456,
             8'h80, 27'h491A2B0, 27'h491A2B0, 0, 0, 0, 1, 0, 1);
    run_pair("denorm", 0, 8'h00, 23'h000001, 0, 8'h01, 23'h0,
             8'h01, 27'h4000000, 27'h0000008, 1, 0, 1, 0, 0, 0);

    // Backpressure: 6 pairs, a = 2^i * b, out_ready low for cycles 3..5.
    ni = 0; no = 0; stalled = 0; saw_low = 0;
    hold_exp = '0; hold_small = '0;
    for (int cyc = 0; cyc < 40 && no < 6; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid  = (ni < 6);
      drive(0, 8'(8'h80 + ni), 23'h0, 0, 8'h80, 23'h0);
      @(negedge clk);
      if (stalled) begin
        chk("bp_hold_exp",   32'(bus.exp_big),   32'(hold_exp));
        chk("bp_hold_small", 32'(bus.sig_small), 32'(hold_small));
      end
      if (!bus.in_ready) saw_low = 1;
      stalled = bus.out_valid && !bus.out_ready;
      hold_exp = bus.exp_big; hold_small = bus.sig_small;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_exp_big",   32'(bus.exp_big),   32'(8'(8'h80 + no)));
        chk("bp_sig_small", 32'(bus.sig_small), 32'(27'h4000000 >> no));
        no++;
      end
      if (bus.in_valid && bus.in_ready) ni++;
      @(posedge clk); #1;
    end
    chk("bp_count", 32'(no), 32'd6);
    chk("bp_in_ready_low", 32'(saw_low), 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(1, 8'h85, 23'h7FFFFF, 0, 8'h80, 23'h1);
    @(posedge clk); #1;
    drive(0, 8'h90, 23'h0, 1, 8'h70, 23'h5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
    chk("mid_rst_data", 32'(bus.sig_big | bus.sig_small), 32'd0);
    chk("mid_rst_misc", 32'({bus.exp_big, bus.sign_big, bus.sign_small, bus.swapped,
                             bus.a_greater, bus.a_less, bus.a_equal}), 32'd0);
    @(posedge clk); #1;
    run_pair("post_rst", 0, 8'h81, 23'h0, 0, 8'h82, 23'h0,
             8'h82, 27'h4000000, 27'h2000000, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_drain", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
